// File: rtl/booth_shreg_gen.sv
// ---------------------------------------------------------------------------
// booth_shreg_gen
//
// Multi-mode shift register for the Booth multiplier datapath. Holds the
// accumulator/multiplier word. It supports parallel load, single-step shifts
// issued by the Booth controller, and multi-position shift commands. A
// multi-position command runs one bit per cycle under a start/busy/done
// handshake.
//
// Parameters:
//   WIDTH  register width in bits (>= 2)
//   SH_W   width of the shift-amount port
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   load      parallel load of data_in (also aborts a running command)
//   data_in   load value
//   mode      00 logical right, 01 arithmetic right, 10 logical left,
//             11 rotate right
//   fill_in   bit inserted by the logical modes
//   step      single one-position shift while idle
//   start     begin a multi-position shift of 'amount' positions
//   amount    shift count, captured at start
//   data_out  register contents
//   sh_out    bit shifted out by the most recent shift
//   busy      multi-position shift in progress
//   done      one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module booth_shreg_gen #(
   parameter int WIDTH = 16,
   parameter int SH_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       mode,
   input  logic             fill_in,
   input  logic             step,
   input  logic             start,
   input  logic [SH_W-1:0]  amount,
   output logic [WIDTH-1:0] data_out,
   output logic             sh_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state, state_d;
   logic [WIDTH-1:0]  q, q_d;
   logic              sh_q, sh_d;
   logic              done_q, done_d;
   logic [SH_W-1:0]   cnt, cnt_d;
   logic [1:0]        mode_q, mode_q_d;

   logic [1:0]        sel_mode;
   logic [WIDTH:0]    shift_res;   // {bit shifted out, new register value}

   // One shift of v in mode m; the MSB of the result is the bit leaving v.
   function automatic logic [WIDTH:0] shift_once(
      input logic [WIDTH-1:0] v,
      input logic [1:0]       m,
      input logic             f
   );
      logic [WIDTH:0] r;
      case (m)
         2'b00:   r = {v[0],       f,          v[WIDTH-1:1]};
         2'b01:   r = {v[0],       v[WIDTH-1], v[WIDTH-1:1]};
         2'b10:   r = {v[WIDTH-1], v[WIDTH-2:0], f};
         default: r = {v[0],       v[0],       v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   // A running command uses the mode captured at start, so live mode
   // changes while busy have no effect.
   assign sel_mode  = (state == SHIFT) ? mode_q : mode;
   assign shift_res = shift_once(q, sel_mode, fill_in);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state;
      q_d      = q;
      sh_d     = sh_q;
      done_d   = 1'b0;
      cnt_d    = cnt;
      mode_q_d = mode_q;

      if (load) begin
         // Load wins over everything but reset and aborts a running command
         // without a done pulse.
         q_d     = data_in;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (amount == '0) begin
                     done_d = 1'b1;
                  end else begin
                     cnt_d    = amount;
                     mode_q_d = mode;
                     state_d  = SHIFT;
                  end
               end else if (step) begin
                  {sh_d, q_d} = shift_res;
               end
            end
            SHIFT: begin
               {sh_d, q_d} = shift_res;
               cnt_d       = cnt - 1'b1;
               if (cnt == SH_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         q      <= '0;
         sh_q   <= 1'b0;
         done_q <= 1'b0;
         cnt    <= '0;
         mode_q <= 2'b00;
      end else begin
         state  <= state_d;
         q      <= q_d;
         sh_q   <= sh_d;
         done_q <= done_d;
         cnt    <= cnt_d;
         mode_q <= mode_q_d;
      end
   end

   // All outputs come straight from registers.
   assign data_out = q;
   assign sh_out   = sh_q;
   assign busy     = (state == SHIFT);
   assign done     = done_q;

endmodule

// File: doc/booth_shreg_gen.md
# booth_shreg_gen

Parametrised multi-mode shift register for the Booth multiplier datapath, replacing the fixed 16-bit single-step right shifter. It supports parallel load, four shift modes, single-step shifts driven by the Booth controller, and multi-position shift commands. Multi-position shifts run one bit per cycle under a start/busy/done handshake. The block holds the accumulator/multiplier words and also serves as a general-purpose shifter elsewhere in the arithmetic unit.

## Interface
- WIDTH, 16, register width in bits (≥2)
- SH_W, 5, width of the shift-amount port; maximum command is 2^SH_W−1 positions

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- load  in  1  parallel load of data_in
- data_in  in  WIDTH  load value
- mode  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right
- fill_in  in  1  bit inserted by logical modes (MSB for right, LSB for left)
- step  in  1  single one-position shift when idle
- start  in  1  begin multi-position shift of amount positions
- amount  in  SH_W  shift count, captured at start
- data_out  out  WIDTH  register contents
- sh_out  out  1  bit shifted out by the most recent shift
- busy  out  1  multi-position shift in progress
- done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE, SHIFT. The counter cnt (SH_W bits) and the mode latch mode_q are loaded at start.
- Priority at each edge: rst > load > (IDLE: start > step) / (SHIFT: shift).
- One shift applied to Q:
  - 00: Q = {fill_in, Q[W-1:1]}, out Q[0]
  - 01: Q = {Q[W-1], Q[W-1:1]}, out Q[0]
  - 10: Q = {Q[W-2:0], fill_in}, out Q[W-1]
  - 11: Q = {Q[0], Q[W-1:1]}, out Q[0]
- Every shift updates sh_out at the same edge. Load and reset do not update sh_out, except that reset clears it.
- step in IDLE: one shift using the live mode. No busy or done.
- start in IDLE with amount=N≥1: capture N and mode, go to SHIFT, busy=1. Each SHIFT cycle shifts once using mode_q and decrements cnt. The edge that applies the Nth shift returns to IDLE, clears busy, and pulses done.
- start with amount=0: stay IDLE, Q unchanged, done pulses for one cycle.
- Counts ≥ WIDTH are executed literally. Logical modes end fully filled. Arithmetic mode ends at all sign bits. Rotate wraps modulo WIDTH.
- While busy: start and step are ignored. mode changes have no effect because mode_q is used.
- load while busy: abort. Q=data_in, return to IDLE, busy=0, no done pulse.
- rst at any time: Q=0, sh_out=0, busy=0, done=0, cnt=0, state IDLE.

## Timing
- Reset values: data_out=0, sh_out=0, busy=0, done=0.
- load, step: data_out reflects the result one edge after sampling.
- start sampled at edge k, N≥1:
  - busy=1 after edge k.
  - Shifts occur at edges k+1…k+N.
  - After edge k+N: busy=0, done=1 for exactly one cycle.
  - Total latency N+1 cycles.
- start at edge k, N=0: done=1 after edge k, for one cycle.
- A new start may be accepted in the cycle done is high, since the block is already IDLE.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=16. load 0x8001, mode=01, start amount=3 → busy for 3 cycles, data_out 0xC000, 0xE000, 0xF000; sh_out 1, 0, 0; done pulses once.
- load 0x4001, mode=10, fill_in=0, two step pulses → 0x8002 then 0x0004; sh_out 0 then 1; busy and done stay 0.
- load 0x0001, mode=11, start amount=17 → after 17 shifts data_out=0x8000, sh_out=1, done after 18 cycles.
- load 0x0000, mode=00, fill_in=1, start amount=20 → 0xF000 after 4 shifts, 0xFFFF final.
- start amount=5, then load 0x1234 during the 2nd shift cycle → data_out=0x1234, busy=0, no done. A following start amount=0 → done for one cycle, data_out unchanged.
- rst during SHIFT → next cycle data_out=0, sh_out=0, busy=0, done=0. start, step, and mode toggles while busy leave the result identical to an undisturbed run.
